instruction_fetch: RTL and testbench

//  Consumer side of the program counter interface: reads pc_value, fetches the instruction word from instruction memory

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch_watchdog.sv | 30 +++
 rtl/instruction_fetch.sv | 154 +++++++++++++++
 tb/tb_instruction_fetch.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and opcode decoding.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_HOLD   = 3'd1,
    S_STEP   = 3'd2,
    S_REDIR  = 3'd3,
    S_SETTLE = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } fetch_state_t;

  localparam logic [3:0] OPC_HALT = 4'hF;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/instruction_fetch_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear; expired is combinational and
// flags the LIMIT-th enabled cycle.
module instruction_fetch_watchdog #(
  parameter int          TMO_W = 16,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/instruction_fetch.sv
// Fetches imem[pc] over req/ack, presents it to decode over valid/ready, then steps or redirects the PC.
// Sequential fetch-to-fetch is 4 cycles with a 1-cycle ack; decode stalls hold the word in S_HOLD.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [3:0]  HALT_OPCODE = OPC_HALT,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int          TMO_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_value,
  output logic        increment,
  output logic        jump_enable,
  output logic        return_enable,
  output logic [15:0] jump_address,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_out,
  input  logic        branch_req,
  input  logic [15:0] branch_target,
  input  logic        return_req,
  output logic        halted,
  output logic        fetch_error
);

  fetch_state_t state;

  logic        pend_vld;
  logic        pend_ret;
  logic [15:0] pend_target;

  logic        redir_any;
  logic        redir_ret;
  logic [15:0] redir_target;
  logic        wd_expired;

  // A request seen this cycle overrides anything already pending; branch beats return.
  always_comb begin
    redir_any    = pend_vld;
    redir_ret    = pend_ret;
    redir_target = pend_target;
    if (state == S_FETCH || state == S_HOLD) begin
      if (branch_req) begin
        redir_any    = 1'b1;
        redir_ret    = 1'b0;
        redir_target = branch_target;
      end else if (return_req) begin
        redir_any    = 1'b1;
        redir_ret    = 1'b1;
      end
    end
  end

  instruction_fetch_watchdog #(
    .TMO_W (TMO_W),
    .LIMIT (ACK_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state != S_FETCH),
    .en      ((state == S_FETCH) && !imem_ack),
    .expired (wd_expired)
  );

  // Reset parks in S_SETTLE so the first edge after release latches pc_value and raises imem_req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_SETTLE;
      increment     <= 1'b0;
      jump_enable   <= 1'b0;
      return_enable <= 1'b0;
      jump_address  <= '0;
      imem_req      <= 1'b0;
      imem_addr     <= '0;
      instr_valid   <= 1'b0;
      instr_out     <= '0;
      halted        <= 1'b0;
      fetch_error   <= 1'b0;
      pend_vld      <= 1'b0;
      pend_ret      <= 1'b0;
      pend_target   <= '0;
    end else begin
      increment     <= 1'b0;
      jump_enable   <= 1'b0;
      return_enable <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (redir_any) begin
              state    <= S_REDIR;
              pend_vld <= 1'b0;
              if (redir_ret) begin
                return_enable <= 1'b1;
              end else begin
                jump_enable  <= 1'b1;
                jump_address <= redir_target;
              end
            end else begin
              instr_out   <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end
          end else if (wd_expired) begin
            imem_req    <= 1'b0;
            fetch_error <= 1'b1;
            state       <= S_ERROR;
          end else begin
            pend_vld    <= redir_any;
            pend_ret    <= redir_ret;
            pend_target <= redir_target;
          end
        end
        S_HOLD: begin
          if (instr_ready && opcode_of(instr_out) == HALT_OPCODE) begin
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            state       <= S_HALT;
          end else if (redir_any) begin
            instr_valid <= 1'b0;
            pend_vld    <= 1'b0;
            state       <= S_REDIR;
            if (redir_ret) begin
              return_enable <= 1'b1;
            end else begin
              jump_enable  <= 1'b1;
              jump_address <= redir_target;
            end
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            increment   <= 1'b1;
            state       <= S_STEP;
          end
        end
        S_STEP, S_REDIR: begin
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          imem_req  <= 1'b1;
          imem_addr <= pc_value;
          state     <= S_FETCH;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC and memory environment models, a monitor, and a per-scenario task list.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc_value;
  logic [15:0] ret_addr;
  logic        increment, jump_enable, return_enable;
  logic [15:0] jump_address;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_out;
  logic        branch_req = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic        return_req = 1'b0;
  logic        halted, fetch_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .HALT_OPCODE (4'hF),
    .ACK_TIMEOUT (8),
    .TMO_W       (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_value      (pc_value),
    .increment     (increment),
    .jump_enable   (jump_enable),
    .return_enable (return_enable),
    .jump_address  (jump_address),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_out     (instr_out),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .return_req    (return_req),
    .halted        (halted),
    .fetch_error   (fetch_error)
  );

  // Program counter environment: a call saves pc+1 as the return address.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_value <= 16'h0;
      ret_addr <= 16'h0;
    end else if (increment) begin
      pc_value <= pc_value + 16'd1;
    end else if (jump_enable) begin
      ret_addr <= pc_value + 16'd1;
      pc_value <= jump_address;
    end else if (return_enable) begin
      pc_value <= ret_addr;
    end
  end

  // Instruction memory: acknowledges after cur_delay waiting cycles.
  logic [15:0] mem [0:255];
  bit mem_en    = 1'b0;
  bit ack_rand  = 1'b0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  int cur_delay = 0;

  always @(negedge clk) begin
    if (reset || !imem_req || !mem_en) begin
      imem_ack  = 1'b0;
      wait_cnt  = 0;
      cur_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
    end else if (wait_cnt >= cur_delay) begin
      imem_ack   = 1'b1;
      imem_rdata = mem[imem_addr[7:0]];
    end else begin
      imem_ack = 1'b0;
      wait_cnt++;
    end
  end

  // Monitor: records fetch addresses, delivered words and strobes; cleared while reset is high.
  int          cyc = 0;
  logic        req_d = 1'b0;
  logic [15:0] fetch_q [$];
  int          fetch_cyc_q [$];
  logic [15:0] deliv_q [$];
  logic [15:0] jmp_q [$];
  int          n_inc = 0, n_jmp = 0, n_ret = 0, multi = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      req_d = 1'b0;
      fetch_q.delete();
      fetch_cyc_q.delete();
      deliv_q.delete();
      jmp_q.delete();
      n_inc = 0;
      n_jmp = 0;
      n_ret = 0;
      multi = 0;
    end else begin
      if (imem_req && !req_d) begin
        fetch_q.push_back(imem_addr);
        fetch_cyc_q.push_back(cyc);
      end
      req_d = imem_req;
      if (instr_valid && instr_ready) deliv_q.push_back(instr_out);
      if (increment) n_inc++;
      if (jump_enable) begin
        n_jmp++;
        jmp_q.push_back(jump_address);
      end
      if (return_enable) n_ret++;
      if (int'(increment) + int'(jump_enable) + int'(return_enable) > 1) multi++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    instr_ready   = 1'b0;
    branch_req    = 1'b0;
    return_req    = 1'b0;
    branch_target = 16'h0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    mem_en = 1'b0;
    step(2);
    n_checks++;
    if ({imem_req, instr_valid, increment, jump_enable, return_enable, halted, fetch_error} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {imem_req, instr_valid, increment, jump_enable, return_enable, halted, fetch_error});
    end
    n_checks++;
    if ({imem_addr, instr_out, jump_address} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {imem_addr, instr_out, jump_address});
    end
    reset = 1'b0;
    step(1);
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    int n;
    int t;
    for (int pass = 0; pass < 2; pass++) begin
      fill_mem();
      mem[0]    = 16'h1234;
      mem_en    = 1'b1;
      ack_rand  = (pass == 1);
      ack_delay = 0;
      n         = 12;
      do_reset();
      instr_ready = 1'b1;
      t = 0;
      while (deliv_q.size() < n && t < 300) begin
        step(1);
        t++;
      end
      instr_ready = 1'b0;
      step(10);
      n_checks++;
      if (deliv_q.size() != n) begin
        n_fail++;
        $display("FAIL seq_count pass%0d: got %0d words expected %0d", pass, deliv_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          n_checks++;
          if (fetch_q[i] !== 16'(i) || deliv_q[i] !== mem[i]) begin
            n_fail++;
            $display("FAIL seq_word pass%0d #%0d: got addr=%h data=%h expected addr=%h data=%h",
                     pass, i, fetch_q[i], deliv_q[i], 16'(i), mem[i]);
          end
        end
      end
      n_checks++;
      if (n_inc != n || fetch_q.size() != n + 1 || !instr_valid || instr_out !== mem[n]) begin
        n_fail++;
        $display("FAIL seq_tail pass%0d: got inc=%0d fetches=%0d valid=%b out=%h expected %0d %0d 1 %h",
                 pass, n_inc, fetch_q.size(), instr_valid, instr_out, n, n + 1, mem[n]);
      end
      if (pass == 0) begin
        n_checks++;
        if (fetch_cyc_q[1] - fetch_cyc_q[0] != 4) begin
          n_fail++;
          $display("FAIL seq_latency: got %0d cycles expected 4", fetch_cyc_q[1] - fetch_cyc_q[0]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int t;
    fill_mem();
    mem_en    = 1'b1;
    ack_rand  = 1'b0;
    ack_delay = 0;
    do_reset();
    t = 0;
    while (!instr_valid && t < 20) begin
      step(1);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++;
      if (!instr_valid || instr_out !== mem[0] || n_inc != 0) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d: got valid=%b out=%h inc=%0d expected 1 %h 0",
                 i, instr_valid, instr_out, n_inc, mem[0]);
      end
    end
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    step(6);
    n_checks++;
    if (n_inc != 1 || deliv_q.size() != 1 || fetch_q.size() != 2 || fetch_q[1] !== 16'h1) begin
      n_fail++;
      $display("FAIL stall_release: got inc=%0d words=%0d fetches=%0d expected 1 1 2", n_inc,
               deliv_q.size(), fetch_q.size());
    end
  endtask

  task automatic test_branch_fetch();
    int t;
    fill_mem();
    mem_en    = 1'b1;
    ack_rand  = 1'b0;
    ack_delay = 3;
    do_reset();
    instr_ready = 1'b1;
    step(1);
    branch_req    = 1'b1;
    branch_target = 16'h0040;
    step(1);
    branch_req = 1'b0;
    t = 0;
    while (deliv_q.size() < 1 && t < 40) begin
      step(1);
      t++;
    end
    instr_ready = 1'b0;
    step(6);
    n_checks++;
    if (deliv_q.size() < 1 || deliv_q[0] !== mem[8'h40]) begin
      n_fail++;
      $display("FAIL branch_discard: got words=%0d expected first word %h", deliv_q.size(), mem[8'h40]);
    end
    n_checks++;
    if (n_jmp != 1 || jmp_q.size() != 1 || jmp_q[0] !== 16'h0040 || n_ret != 0) begin
      n_fail++;
      $display("FAIL branch_jump: got jmp=%0d ret=%0d expected one jump to 0040", n_jmp, n_ret);
    end
    n_checks++;
    if (fetch_q.size() < 2 || fetch_q[0] !== 16'h0 || fetch_q[1] !== 16'h0040) begin
      n_fail++;
      $display("FAIL branch_addr: got fetches=%0d expected 0000 then 0040", fetch_q.size());
    end
  endtask

  task automatic test_branch_return();
    int t;
    logic [15:0] tgt;
    fill_mem();
    mem_en    = 1'b1;
    ack_rand  = 1'b0;
    ack_delay = 0;
    do_reset();
    tgt = 16'($urandom_range(16, 200));
    t = 0;
    while (!instr_valid && t < 20) begin
      step(1);
      t++;
    end
    branch_req    = 1'b1;
    return_req    = 1'b1;
    branch_target = tgt;
    t = 0;
    while (instr_valid && t < 5) begin
      step(1);
      t++;
    end
    branch_req = 1'b0;
    return_req = 1'b0;
    t = 0;
    while (!instr_valid && t < 20) begin
      step(1);
      t++;
    end
    n_checks++;
    if (n_jmp != 1 || n_ret != 0 || jmp_q.size() != 1 || jmp_q[0] !== tgt || instr_out !== mem[tgt[7:0]]) begin
      n_fail++;
      $display("FAIL both_req: got jmp=%0d ret=%0d out=%h expected one jump to %h out=%h",
               n_jmp, n_ret, instr_out, tgt, mem[tgt[7:0]]);
    end
    return_req = 1'b1;
    t = 0;
    while (instr_valid && t < 5) begin
      step(1);
      t++;
    end
    return_req = 1'b0;
    t = 0;
    while (!instr_valid && t < 20) begin
      step(1);
      t++;
    end
    n_checks++;
    if (n_ret != 1 || n_jmp != 1 || n_inc != 0 || deliv_q.size() != 0) begin
      n_fail++;
      $display("FAIL return_strobes: got ret=%0d jmp=%0d inc=%0d words=%0d expected 1 1 0 0",
               n_ret, n_jmp, n_inc, deliv_q.size());
    end
    n_checks++;
    if (fetch_q.size() != 3 || fetch_q[2] !== 16'h1 || instr_out !== mem[1]) begin
      n_fail++;
      $display("FAIL return_addr: got fetches=%0d out=%h expected 3 fetches ending at 0001 out=%h",
               fetch_q.size(), instr_out, mem[1]);
    end
    n_checks++;
    if (multi != 0) begin
      n_fail++;
      $display("FAIL one_strobe: got %0d overlapping cycles expected 0", multi);
    end
  endtask

  task automatic test_halt();
    int t;
    int k;
    int viol;
    int nf;
    fill_mem();
    k    = int'($urandom_range(1, 4));
    mem[k] = {4'hF, 12'($urandom)};
    mem_en   = 1'b1;
    ack_rand = 1'b1;
    do_reset();
    instr_ready = 1'b1;
    t = 0;
    while (!halted && t < 100) begin
      step(1);
      t++;
    end
    n_checks++;
    if (!halted || deliv_q.size() != k + 1 || deliv_q[k] !== mem[k] || n_inc != k) begin
      n_fail++;
      $display("FAIL halt_enter: got halted=%b words=%0d inc=%0d expected 1 %0d %0d",
               halted, deliv_q.size(), n_inc, k + 1, k);
    end
    nf   = fetch_q.size();
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      branch_req    = 1'($urandom);
      return_req    = 1'($urandom);
      instr_ready   = 1'($urandom);
      branch_target = 16'($urandom);
      step(1);
      if (imem_req || instr_valid || increment || jump_enable || return_enable || !halted) viol++;
    end
    n_checks++;
    if (viol != 0 || fetch_q.size() != nf || n_inc != k || n_jmp != 0 || n_ret != 0) begin
      n_fail++;
      $display("FAIL halt_quiet: got %0d active cycles fetches=%0d expected 0 active fetches=%0d",
               viol, fetch_q.size(), nf);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset: got halted=%b expected 0", halted);
    end
    ack_rand = 1'b0;
    do_reset();
  endtask

  task automatic test_timeout();
    int t;
    int reqc;
    fill_mem();
    mem_en = 1'b0;
    do_reset();
    reqc = 0;
    t    = 0;
    while (!fetch_error && t < 50) begin
      if (imem_req) reqc++;
      step(1);
      t++;
    end
    n_checks++;
    if (reqc != 8 || !fetch_error || imem_req) begin
      n_fail++;
      $display("FAIL timeout: got req_cycles=%0d error=%b req=%b expected 8 1 0", reqc, fetch_error, imem_req);
    end
    step(5);
    n_checks++;
    if (!fetch_error || imem_req || fetch_q.size() != 1) begin
      n_fail++;
      $display("FAIL error_quiet: got error=%b req=%b fetches=%0d expected 1 0 1",
               fetch_error, imem_req, fetch_q.size());
    end
    mem_en    = 1'b1;
    ack_delay = 7;
    do_reset();
    instr_ready = 1'b1;
    t = 0;
    while (deliv_q.size() < 1 && t < 30) begin
      step(1);
      t++;
    end
    n_checks++;
    if (fetch_error || deliv_q.size() < 1 || deliv_q[0] !== mem[0]) begin
      n_fail++;
      $display("FAIL ack_at_limit: got error=%b words=%0d expected 0 and word %h",
               fetch_error, deliv_q.size(), mem[0]);
    end
    mem_en = 1'b0;
    do_reset();
    step(4);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b expected 0", imem_req);
    end
    mem_en    = 1'b1;
    ack_delay = 0;
    do_reset();
    instr_ready = 1'b1;
    t = 0;
    while (deliv_q.size() < 1 && t < 30) begin
      step(1);
      t++;
    end
    n_checks++;
    if (fetch_error || fetch_q.size() < 1 || fetch_q[0] !== 16'h0 || deliv_q.size() < 1 || deliv_q[0] !== mem[0]) begin
      n_fail++;
      $display("FAIL reset_restart: got error=%b words=%0d expected clean fetch of %h",
               fetch_error, deliv_q.size(), mem[0]);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_fetch();
    test_branch_return();
    test_halt();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
